vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 149 ++++++++++++++
 tb/tb_vga_timing.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Generates the raster counters, sync pulses and blanked colour outputs for a
// VGA display. The game engine reads PIXEL_H/PIXEL_V and registers a colour
// onto PIXEL one cycle later. This block delays its coordinate-derived flags
// by two cycles so that sync, blanking and colour line up on the pins.
//
// Ports:
//   VGA_CLOCK    in   1   pixel clock, all logic on its rising edge
//   RESET        in   1   synchronous active-high reset
//   PIXEL        in   3   {R,G,B} from the engine, one cycle behind PIXEL_H/V
//   PIXEL_H      out  11  current horizontal count
//   PIXEL_V      out  11  current vertical count
//   FRAME_START  out  1   one-cycle pulse at (0, V_VISIBLE)
//   FRAME_COUNT  out  16  wrapping count of FRAME_START pulses
//   VGA_HS       out  1   horizontal sync, active level SYNC_POL
//   VGA_VS       out  1   vertical sync, active level SYNC_POL
//   VGA_R/G/B    out  1   blanked colour bits
// ---------------------------------------------------------------------------
module vga_timing #(
   parameter int   H_VISIBLE = 800,
   parameter int   H_FRONT   = 56,
   parameter int   H_SYNC    = 120,
   parameter int   H_BACK    = 64,
   parameter int   V_VISIBLE = 600,
   parameter int   V_FRONT   = 37,
   parameter int   V_SYNC    = 6,
   parameter int   V_BACK    = 23,
   parameter logic SYNC_POL  = 1'b1
) (
   input  logic        VGA_CLOCK,
   input  logic        RESET,
   input  logic [2:0]  PIXEL,
   output logic [10:0] PIXEL_H,
   output logic [10:0] PIXEL_V,
   output logic        FRAME_START,
   output logic [15:0] FRAME_COUNT,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_R,
   output logic        VGA_G,
   output logic        VGA_B
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [10:0] next_h;
   logic [10:0] next_v;
   logic        h_wrap;
   logic        v_wrap;

   logic        visible_s0;
   logic        hs_act_s0;
   logic        vs_act_s0;

   logic        visible_s1;
   logic        hs_act_s1;
   logic        vs_act_s1;

   // Next raster position. The >= compares make the counters fall back to
   // zero even if they were ever pushed beyond the last position.
   always_comb begin
      h_wrap = (PIXEL_H >= H_LAST);
      v_wrap = (PIXEL_V >= V_LAST);
      next_h = h_wrap ? 11'd0 : PIXEL_H + 11'd1;
      next_v = PIXEL_V;
      if (h_wrap) begin
         next_v = v_wrap ? 11'd0 : PIXEL_V + 11'd1;
      end
   end

   // Stage 0 flags, derived from the coordinates currently on PIXEL_H/PIXEL_V.
   always_comb begin
      visible_s0 = (PIXEL_H < H_VIS_END) && (PIXEL_V < V_VIS_END);
      hs_act_s0  = (PIXEL_H >= HS_FIRST) && (PIXEL_H <= HS_LAST);
      vs_act_s0  = (PIXEL_V >= VS_FIRST) && (PIXEL_V <= VS_LAST);
   end

   // Raster counters and frame bookkeeping. FRAME_START is decoded from the
   // next position so that it is high in the same cycle the counters show
   // (0, V_VISIBLE), and FRAME_COUNT already includes that pulse.
   always_ff @(posedge VGA_CLOCK) begin
      if (RESET) begin
         PIXEL_H     <= 11'd0;
         PIXEL_V     <= 11'd0;
         FRAME_START <= 1'b0;
         FRAME_COUNT <= 16'd0;
      end else begin
         PIXEL_H     <= next_h;
         PIXEL_V     <= next_v;
         FRAME_START <= (next_h == 11'd0) && (next_v == V_VIS_END);
         if ((next_h == 11'd0) && (next_v == V_VIS_END)) begin
            FRAME_COUNT <= FRAME_COUNT + 16'd1;
         end
      end
   end

   // First pipe stage: holds the flags while the engine registers the colour
   // for the same coordinate onto PIXEL.
   always_ff @(posedge VGA_CLOCK) begin
      if (RESET) begin
         visible_s1 <= 1'b0;
         hs_act_s1  <= 1'b0;
         vs_act_s1  <= 1'b0;
      end else begin
         visible_s1 <= visible_s0;
         hs_act_s1  <= hs_act_s0;
         vs_act_s1  <= vs_act_s0;
      end
   end

   // Second pipe stage doubles as the output register: PIXEL and the delayed
   // flags now refer to the same coordinate, so blanking and sync are applied
   // here. Resetting stage one as well keeps stale colour or sync off the pins
   // in the first cycles after reset release.
   always_ff @(posedge VGA_CLOCK) begin
      if (RESET) begin
         VGA_HS <= ~SYNC_POL;
         VGA_VS <= ~SYNC_POL;
         VGA_R  <= 1'b0;
         VGA_G  <= 1'b0;
         VGA_B  <= 1'b0;
      end else begin
         VGA_HS <= hs_act_s1 ? SYNC_POL : ~SYNC_POL;
         VGA_VS <= vs_act_s1 ? SYNC_POL : ~SYNC_POL;
         if (visible_s1) begin
            VGA_R <= PIXEL[2];
            VGA_G <= PIXEL[1];
            VGA_B <= PIXEL[0];
         end else begin
            VGA_R <= 1'b0;
            VGA_G <= 1'b0;
            VGA_B <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Self-checking bench for vga_timing using a reduced raster (30 x 18) so that
// whole frames fit in a short run. A bench-side raster model tracks the
// expected coordinates; expected pin values are pushed into a scoreboard
// queue as each coordinate appears and popped two cycles later when the DUT
// presents them. The engine colour is a fixed function of the coordinate.
// ---------------------------------------------------------------------------
module tb_vga_timing;

   localparam int   H_VIS   = 16;
   localparam int   H_FP    = 4;
   localparam int   H_SW    = 6;
   localparam int   H_BP    = 4;
   localparam int   V_VIS   = 10;
   localparam int   V_FP    = 3;
   localparam int   V_SW    = 2;
   localparam int   V_BP    = 3;
   localparam logic POL     = 1'b1;
   localparam int   H_TOT   = H_VIS + H_FP + H_SW + H_BP;
   localparam int   V_TOT   = V_VIS + V_FP + V_SW + V_BP;
   localparam int   HS_FIRST = H_VIS + H_FP;
   localparam int   VS_FIRST = V_VIS + V_FP;
   localparam int   FRAME_CYCLES = H_TOT * V_TOT;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [2:0] rgb;
   } vga_exp_t;

   logic        VGA_CLOCK;
   logic        RESET;
   logic [2:0]  PIXEL;
   logic [10:0] PIXEL_H;
   logic [10:0] PIXEL_V;
   logic        FRAME_START;
   logic [15:0] FRAME_COUNT;
   logic        VGA_HS;
   logic        VGA_VS;
   logic        VGA_R;
   logic        VGA_G;
   logic        VGA_B;

   int          checks;
   int          failures;
   int          mh;
   int          mv;
   logic        m_fs;
   logic [15:0] m_fc;
   vga_exp_t    sb[$];
   vga_exp_t    exp_cur;

   vga_timing #(
      .H_VISIBLE (H_VIS),
      .H_FRONT   (H_FP),
      .H_SYNC    (H_SW),
      .H_BACK    (H_BP),
      .V_VISIBLE (V_VIS),
      .V_FRONT   (V_FP),
      .V_SYNC    (V_SW),
      .V_BACK    (V_BP),
      .SYNC_POL  (POL)
   ) dut (
      .VGA_CLOCK   (VGA_CLOCK),
      .RESET       (RESET),
      .PIXEL       (PIXEL),
      .PIXEL_H     (PIXEL_H),
      .PIXEL_V     (PIXEL_V),
      .FRAME_START (FRAME_START),
      .FRAME_COUNT (FRAME_COUNT),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B)
   );

   initial VGA_CLOCK = 1'b0;
   always #10 VGA_CLOCK = ~VGA_CLOCK;

   // Colour the engine produces for a coordinate; (0,0) gives 3'b101.
   function automatic logic [2:0] engine_colour(input int h, input int v);
      return 3'((h + v) ^ 5);
   endfunction

   // Pin values the display should see for a given coordinate.
   function automatic vga_exp_t expect_for(input int h, input int v);
      vga_exp_t e;
      e.hs  = (h >= HS_FIRST && h < HS_FIRST + H_SW) ? POL : ~POL;
      e.vs  = (v >= VS_FIRST && v < VS_FIRST + V_SW) ? POL : ~POL;
      e.rgb = (h < H_VIS && v < V_VIS) ? engine_colour(h, v) : 3'b000;
      return e;
   endfunction

   function automatic vga_exp_t reset_exp();
      vga_exp_t e;
      e.hs  = ~POL;
      e.vs  = ~POL;
      e.rgb = 3'b000;
      return e;
   endfunction

   function automatic vga_exp_t observed();
      vga_exp_t e;
      e.hs  = VGA_HS;
      e.vs  = VGA_VS;
      e.rgb = {VGA_R, VGA_G, VGA_B};
      return e;
   endfunction

   // Advance one clock, step the raster model, act as the engine (colour for
   // the previous coordinate) and move the scoreboard along.
   task automatic tick();
      int prev_h;
      int prev_v;
      @(posedge VGA_CLOCK);
      #1;
      prev_h = mh;
      prev_v = mv;
      if (mh == H_TOT - 1) begin
         mh = 0;
         mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      m_fs = (mh == 0 && mv == V_VIS);
      if (m_fs) m_fc = m_fc + 16'd1;
      PIXEL = engine_colour(prev_h, prev_v);
      sb.push_back(expect_for(mh, mv));
      exp_cur = sb.pop_front();
   endtask

   // Hold reset for a number of edges; the engine drives white meanwhile so
   // any unblanked colour would show.
   task automatic apply_reset(input int cycles);
      RESET = 1'b1;
      PIXEL = 3'b111;
      repeat (cycles) @(posedge VGA_CLOCK);
      #1;
      RESET = 1'b0;
      mh   = 0;
      mv   = 0;
      m_fs = 1'b0;
      m_fc = 16'd0;
      sb.delete();
      sb.push_back(reset_exp());
      sb.push_back(reset_exp());
      sb.push_back(expect_for(0, 0));
      exp_cur = sb.pop_front();
   endtask

   task automatic test_reset();
      apply_reset(3);
      checks++;
      if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_coords: got (%0d,%0d), expected (0,0)", PIXEL_H, PIXEL_V);
      end
      checks++;
      if (FRAME_START !== 1'b0 || FRAME_COUNT !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_frame: got start=%b count=%0d, expected start=0 count=0", FRAME_START, FRAME_COUNT);
      end
      checks++;
      if (observed() !== reset_exp()) begin
         failures++;
         $display("[TB] FAIL reset_pins: got %b, expected %b", observed(), reset_exp());
      end
   endtask

   task automatic test_line_scan();
      int max_h;
      max_h = 0;
      for (int i = 0; i < H_TOT; i++) begin
         tick();
         if (int'(PIXEL_H) > max_h) max_h = int'(PIXEL_H);
         checks++;
         if (PIXEL_H !== 11'(mh) || PIXEL_V !== 11'(mv)) begin
            failures++;
            $display("[TB] FAIL scan_coords: got (%0d,%0d), expected (%0d,%0d)", PIXEL_H, PIXEL_V, mh, mv);
         end
         checks++;
         if (observed() !== exp_cur) begin
            failures++;
            $display("[TB] FAIL scan_pins at (%0d,%0d): got %b, expected %b", mh, mv, observed(), exp_cur);
         end
      end
      checks++;
      if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'd1) begin
         failures++;
         $display("[TB] FAIL line_wrap: got (%0d,%0d), expected (0,1)", PIXEL_H, PIXEL_V);
      end
      checks++;
      if (max_h != H_TOT - 1) begin
         failures++;
         $display("[TB] FAIL line_max: got %0d, expected %0d", max_h, H_TOT - 1);
      end
   endtask

   task automatic test_hsync();
      for (int i = 0; i < H_TOT && mh != HS_FIRST; i++) tick();
      tick();
      checks++;
      if (VGA_HS !== ~POL) begin
         failures++;
         $display("[TB] FAIL hs_before: got %b, expected %b", VGA_HS, ~POL);
      end
      tick();
      checks++;
      if (VGA_HS !== POL || {VGA_R, VGA_G, VGA_B} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL hs_start: got hs=%b rgb=%b, expected hs=%b rgb=000", VGA_HS, {VGA_R, VGA_G, VGA_B}, POL);
      end
      for (int i = 0; i < H_TOT && mh != HS_FIRST + H_SW; i++) tick();
      tick();
      checks++;
      if (VGA_HS !== POL) begin
         failures++;
         $display("[TB] FAIL hs_last: got %b, expected %b", VGA_HS, POL);
      end
      tick();
      checks++;
      if (VGA_HS !== ~POL) begin
         failures++;
         $display("[TB] FAIL hs_end: got %b, expected %b", VGA_HS, ~POL);
      end
   endtask

   task automatic test_colour();
      apply_reset(1);
      tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL colour_warmup: got %b, expected 000", {VGA_R, VGA_G, VGA_B});
      end
      tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== 3'b101) begin
         failures++;
         $display("[TB] FAIL colour_origin: got %b, expected 101", {VGA_R, VGA_G, VGA_B});
      end
      for (int i = 0; i < H_TOT && mh != H_VIS - 1; i++) tick();
      tick();
      tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== engine_colour(H_VIS - 1, 0)) begin
         failures++;
         $display("[TB] FAIL colour_last_visible: got %b, expected %b", {VGA_R, VGA_G, VGA_B}, engine_colour(H_VIS - 1, 0));
      end
      tick();
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL colour_blanked: got %b, expected 000", {VGA_R, VGA_G, VGA_B});
      end
   endtask

   task automatic test_full_frame();
      int pulses;
      int vs_cycles;
      pulses    = 0;
      vs_cycles = 0;
      apply_reset(1);
      for (int i = 0; i < FRAME_CYCLES; i++) begin
         tick();
         if (VGA_VS === POL) vs_cycles++;
         checks++;
         if (PIXEL_H !== 11'(mh) || PIXEL_V !== 11'(mv) || FRAME_START !== m_fs) begin
            failures++;
            $display("[TB] FAIL frame_raster: got (%0d,%0d) start=%b, expected (%0d,%0d) start=%b", PIXEL_H, PIXEL_V, FRAME_START, mh, mv, m_fs);
         end
         checks++;
         if (observed() !== exp_cur) begin
            failures++;
            $display("[TB] FAIL frame_pins at (%0d,%0d): got %b, expected %b", mh, mv, observed(), exp_cur);
         end
         if (FRAME_START === 1'b1) begin
            pulses++;
            checks++;
            if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'(V_VIS)) begin
               failures++;
               $display("[TB] FAIL frame_start_pos: got (%0d,%0d), expected (0,%0d)", PIXEL_H, PIXEL_V, V_VIS);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("[TB] FAIL frame_pulses: got %0d, expected 1", pulses);
      end
      checks++;
      if (vs_cycles != V_SW * H_TOT) begin
         failures++;
         $display("[TB] FAIL vs_width: got %0d, expected %0d", vs_cycles, V_SW * H_TOT);
      end
      checks++;
      if (FRAME_COUNT !== 16'd1) begin
         failures++;
         $display("[TB] FAIL frame_count: got %0d, expected 1", FRAME_COUNT);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < FRAME_CYCLES; i++) begin
         tick();
         checks++;
         if (FRAME_START !== m_fs || FRAME_COUNT !== m_fc) begin
            failures++;
            $display("[TB] FAIL b2b_frame: got start=%b count=%0d, expected start=%b count=%0d", FRAME_START, FRAME_COUNT, m_fs, m_fc);
         end
      end
      checks++;
      if (FRAME_COUNT !== 16'd2) begin
         failures++;
         $display("[TB] FAIL b2b_count: got %0d, expected 2", FRAME_COUNT);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < FRAME_CYCLES && !(mh == 12 && mv == 5); i++) tick();
      apply_reset(1);
      checks++;
      if (PIXEL_H !== 11'd0 || PIXEL_V !== 11'd0 || FRAME_START !== 1'b0 || FRAME_COUNT !== 16'd0) begin
         failures++;
         $display("[TB] FAIL midreset_state: got (%0d,%0d) start=%b count=%0d, expected (0,0) 0 0", PIXEL_H, PIXEL_V, FRAME_START, FRAME_COUNT);
      end
      checks++;
      if (observed() !== reset_exp()) begin
         failures++;
         $display("[TB] FAIL midreset_pins: got %b, expected %b", observed(), reset_exp());
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (PIXEL_H !== 11'(i) || PIXEL_V !== 11'd0) begin
            failures++;
            $display("[TB] FAIL midreset_restart: got (%0d,%0d), expected (%0d,0)", PIXEL_H, PIXEL_V, i);
         end
         checks++;
         if (observed() !== exp_cur) begin
            failures++;
            $display("[TB] FAIL midreset_pins_after: got %b, expected %b", observed(), exp_cur);
         end
      end
   endtask

   // Run the scenarios in order; later ones rely on the raster position the
   // earlier ones leave behind.
   initial begin
      checks   = 0;
      failures = 0;
      RESET    = 1'b1;
      PIXEL    = 3'b000;
      mh       = 0;
      mv       = 0;
      m_fs     = 1'b0;
      m_fc     = 16'd0;
      test_reset();
      test_line_scan();
      test_hsync();
      test_colour();
      test_full_frame();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Guard against the run never completing.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation still running after %0d time units, expected completion", 400000);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
